// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline run controller: host opcodes, FSM states
// and the default drain length.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_WRITE_IMEM = 3'd1,
    OP_RUN        = 3'd2,
    OP_HALT       = 3'd3,
    OP_STEP       = 3'd4,
    OP_LOAD_PC    = 3'd5,
    OP_SET_BP     = 3'd6,
    OP_CLR_BP     = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int DEFAULT_DRAIN_CYCLES = 4;

endpackage

// File: rtl/pipe_ctrl_bp.sv
// Single hardware breakpoint: address register, valid flag and PC comparator.
module pipe_ctrl_bp
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bp_set,
  input  logic            bp_clr,
  input  logic [PC_W-1:0] set_addr,
  input  logic [PC_W-1:0] pc,
  output logic            bp_hit,
  output logic [PC_W-1:0] bp_addr
);

  logic            bp_valid_q, bp_valid_d;
  logic [PC_W-1:0] bp_addr_q, bp_addr_d;

  always_comb begin
    bp_valid_d = bp_valid_q;
    bp_addr_d  = bp_addr_q;
    if (bp_set) begin
      bp_valid_d = 1'b1;
      bp_addr_d  = set_addr;
    end else if (bp_clr) begin
      bp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bp_valid_q <= 1'b0;
      bp_addr_q  <= '0;
    end else begin
      bp_valid_q <= bp_valid_d;
      bp_addr_q  <= bp_addr_d;
    end
  end

  assign bp_hit  = bp_valid_q && (pc == bp_addr_q);
  assign bp_addr = bp_addr_q;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/halt sequencer and Icache port arbiter for the 5-stage pipeline.
// Breakpoint support is compiled in when PIPE_CTRL_BREAKPOINT_EN is defined.
module pipeline_run_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W         = 9,
  parameter int DATA_W       = 32,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [PC_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [PC_W-1:0]   pc_if,
  output logic [PC_W-1:0]   imem_addr,
  output logic [DATA_W-1:0] imem_din,
  output logic              imem_we,
  output logic              pipe_en,
  output logic              fetch_bubble,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_load_addr,
  output logic              halted,
  output logic              cmd_err,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);

  state_e            state_q, state_d;
  logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [PC_W-1:0]   resume_pc_q, resume_pc_d;
  logic [PC_W-1:0]   imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0] imem_din_q, imem_din_d;
  logic              imem_we_q, imem_we_d;
  logic              pipe_en_q, pipe_en_d;
  logic              fetch_bubble_q, fetch_bubble_d;
  logic              pc_load_q, pc_load_d;
  logic [PC_W-1:0]   pc_load_addr_q, pc_load_addr_d;
  logic              halted_q, halted_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              cmd_err_q, cmd_err_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;

  cmd_op_e           op;
  logic              accept;
  logic              enter_drain;
  logic [PC_W-1:0]   drain_pc;

  assign op     = cmd_op_e'(cmd_op);
  assign accept = cmd_valid && cmd_ready_q;

`ifdef PIPE_CTRL_BREAKPOINT_EN
  logic            bp_set, bp_clr, bp_hit;
  logic [PC_W-1:0] bp_addr;

  pipe_ctrl_bp #(.PC_W(PC_W)) u_bp (
    .clk      (clk),
    .rst      (rst),
    .bp_set   (bp_set),
    .bp_clr   (bp_clr),
    .set_addr (cmd_addr),
    .pc       (pc_if),
    .bp_hit   (bp_hit),
    .bp_addr  (bp_addr)
  );
`endif

  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    resume_pc_d    = resume_pc_q;
    imem_addr_d    = imem_addr_q;
    imem_din_d     = imem_din_q;
    imem_we_d      = 1'b0;
    pc_load_d      = 1'b0;
    pc_load_addr_d = pc_load_addr_q;
    cmd_err_d      = cmd_err_q;
    cycle_cnt_d    = cycle_cnt_q;
    enter_drain    = 1'b0;
    drain_pc       = pc_if;
`ifdef PIPE_CTRL_BREAKPOINT_EN
    bp_set         = 1'b0;
    bp_clr         = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_err_d = 1'b0;
          case (op)
            OP_WRITE_IMEM: begin
              imem_we_d   = 1'b1;
              imem_addr_d = cmd_addr;
              imem_din_d  = cmd_wdata;
            end
            OP_LOAD_PC: begin
              pc_load_d      = 1'b1;
              pc_load_addr_d = cmd_addr;
            end
            OP_RUN:  state_d = ST_RUN;
            OP_STEP: state_d = ST_STEP;
`ifdef PIPE_CTRL_BREAKPOINT_EN
            OP_SET_BP: bp_set = 1'b1;
            OP_CLR_BP: bp_clr = 1'b1;
`endif
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cycle_cnt_q != {CNT_W{1'b1}}) cycle_cnt_d = cycle_cnt_q + 1'b1;
`ifdef PIPE_CTRL_BREAKPOINT_EN
        if (bp_hit) begin
          enter_drain = 1'b1;
          drain_pc    = bp_addr;
        end else if (accept && op == OP_HALT) begin
          enter_drain = 1'b1;
        end
        if (accept && op != OP_NOP && op != OP_HALT) cmd_err_d = 1'b1;
`else
        if (accept && op == OP_HALT) enter_drain = 1'b1;
        if (accept && op != OP_NOP && op != OP_HALT &&
            op != OP_SET_BP && op != OP_CLR_BP) cmd_err_d = 1'b1;
`endif
      end
      ST_STEP: begin
        // The stepped instruction was fetched this cycle, so resume after it.
        enter_drain = 1'b1;
        drain_pc    = pc_if + 1'b1;
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d        = ST_IDLE;
          pc_load_d      = 1'b1;
          pc_load_addr_d = resume_pc_q;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_drain) begin
      state_d     = ST_DRAIN;
      drain_cnt_d = DCNT_W'(DRAIN_CYCLES - 1);
      resume_pc_d = drain_pc;
    end

    // Status outputs are registered from the next state so they line up with it.
    pipe_en_d      = (state_d != ST_IDLE);
    fetch_bubble_d = (state_d == ST_DRAIN);
    cmd_ready_d    = (state_d == ST_IDLE) || (state_d == ST_RUN);
    halted_d       = (state_d == ST_IDLE) && (state_q != ST_DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      drain_cnt_q    <= '0;
      resume_pc_q    <= '0;
      imem_addr_q    <= '0;
      imem_din_q     <= '0;
      imem_we_q      <= 1'b0;
      pipe_en_q      <= 1'b0;
      fetch_bubble_q <= 1'b0;
      pc_load_q      <= 1'b0;
      pc_load_addr_q <= '0;
      halted_q       <= 1'b1;
      cmd_ready_q    <= 1'b0;
      cmd_err_q      <= 1'b0;
      cycle_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      resume_pc_q    <= resume_pc_d;
      imem_addr_q    <= imem_addr_d;
      imem_din_q     <= imem_din_d;
      imem_we_q      <= imem_we_d;
      pipe_en_q      <= pipe_en_d;
      fetch_bubble_q <= fetch_bubble_d;
      pc_load_q      <= pc_load_d;
      pc_load_addr_q <= pc_load_addr_d;
      halted_q       <= halted_d;
      cmd_ready_q    <= cmd_ready_d;
      cmd_err_q      <= cmd_err_d;
      cycle_cnt_q    <= cycle_cnt_d;
    end
  end

  // Outside IDLE the Icache port follows the fetch PC with no register stage.
  assign imem_addr    = (state_q == ST_IDLE) ? imem_addr_q : pc_if;
  assign imem_din     = imem_din_q;
  assign imem_we      = imem_we_q;
  assign pipe_en      = pipe_en_q;
  assign fetch_bubble = fetch_bubble_q;
  assign pc_load      = pc_load_q;
  assign pc_load_addr = pc_load_addr_q;
  assign halted       = halted_q;
  assign cmd_ready    = cmd_ready_q;
  assign cmd_err      = cmd_err_q;
  assign cycle_cnt    = cycle_cnt_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl with a small fetch-PC model standing in
// for the datapath; breakpoint scenario runs when PIPE_CTRL_BREAKPOINT_EN is set.
module tb_pipeline_run_ctrl;

  localparam logic [2:0] NOP = 3'd0, WR = 3'd1, RUN = 3'd2, HALT = 3'd3;
  localparam logic [2:0] STEP = 3'd4, LDPC = 3'd5, SETBP = 3'd6, CLRBP = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [8:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [8:0]  pc_if;
  logic [8:0]  imem_addr;
  logic [31:0] imem_din;
  logic        imem_we, pipe_en, fetch_bubble, pc_load, halted, cmd_err;
  logic [8:0]  pc_load_addr;
  logic [31:0] cycle_cnt;

  int vectors = 0;
  int miscompares = 0;

  pipeline_run_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .pc_if(pc_if),
    .imem_addr(imem_addr), .imem_din(imem_din), .imem_we(imem_we),
    .pipe_en(pipe_en), .fetch_bubble(fetch_bubble), .pc_load(pc_load),
    .pc_load_addr(pc_load_addr), .halted(halted), .cmd_err(cmd_err),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // Datapath PC: loads on pc_load, otherwise advances whenever the pipe is enabled.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_if <= '0;
    else if (pc_load) pc_if <= pc_load_addr;
    else if (pipe_en) pc_if <= pc_if + 9'd1;
  end

  task automatic send_cmd(input logic [2:0] op, input logic [8:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = NOP;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_halted: got %b want 1", halted); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    vectors++; if ({pipe_en, fetch_bubble, imem_we, pc_load, cmd_err} !== 5'b0) begin miscompares++; $display("[TB] FAIL rst_flags: got %b want 00000", {pipe_en, fetch_bubble, imem_we, pc_load, cmd_err}); end
    vectors++; if (cycle_cnt !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_cycle_cnt: got %0d want 0", cycle_cnt); end
    vectors++; if ({imem_addr, pc_load_addr, imem_din} !== 50'd0) begin miscompares++; $display("[TB] FAIL rst_buses: got %h/%h/%h want 0", imem_addr, pc_load_addr, imem_din); end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_ready_after: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write_imem;
    send_cmd(WR, 9'h010, 32'hDEADBEEF);
    vectors++; if (imem_we !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_we: got %b want 1", imem_we); end
    vectors++; if (imem_addr !== 9'h010) begin miscompares++; $display("[TB] FAIL wr_addr: got %h want 010", imem_addr); end
    vectors++; if (imem_din !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL wr_din: got %h want deadbeef", imem_din); end
    vectors++; if (pipe_en !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_pipe_en: got %b want 0", pipe_en); end
    @(posedge clk); #1;
    vectors++; if (imem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_we_one_cycle: got %b want 0", imem_we); end
    send_cmd(WR, 9'h1FF, 32'h0000_00A5);
    vectors++; if ({imem_we, imem_addr, imem_din} !== {1'b1, 9'h1FF, 32'h0000_00A5}) begin miscompares++; $display("[TB] FAIL wr_top_addr: got %b/%h/%h want 1/1ff/000000a5", imem_we, imem_addr, imem_din); end
    @(posedge clk); #1;
  endtask

  task automatic test_run_halt;
    send_cmd(LDPC, 9'h010, 32'd0);
    vectors++; if ({pc_load, pc_load_addr} !== {1'b1, 9'h010}) begin miscompares++; $display("[TB] FAIL ldpc: got %b/%h want 1/010", pc_load, pc_load_addr); end
    send_cmd(RUN, 9'd0, 32'd0);
    vectors++; if ({pipe_en, halted, pc_load} !== 3'b100) begin miscompares++; $display("[TB] FAIL run_enter: got %b want 100", {pipe_en, halted, pc_load}); end
    repeat (19) @(posedge clk);
    #1;
    vectors++; if (imem_addr !== 9'h023) begin miscompares++; $display("[TB] FAIL run_imem_addr: got %h want 023", imem_addr); end
    send_cmd(HALT, 9'd0, 32'd0);
    vectors++; if (cycle_cnt !== 32'd20) begin miscompares++; $display("[TB] FAIL halt_cycle_cnt: got %0d want 20", cycle_cnt); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_ready: got %b want 0", cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if ({pipe_en, fetch_bubble, pc_load} !== 3'b110) begin miscompares++; $display("[TB] FAIL drain_cycle%0d: got %b want 110", i, {pipe_en, fetch_bubble, pc_load}); end
      @(posedge clk); #1;
    end
    vectors++; if ({pc_load, pc_load_addr} !== {1'b1, 9'h023}) begin miscompares++; $display("[TB] FAIL halt_pc_load: got %b/%h want 1/023", pc_load, pc_load_addr); end
    vectors++; if ({pipe_en, fetch_bubble, halted} !== 3'b000) begin miscompares++; $display("[TB] FAIL halt_exit_flags: got %b want 000", {pipe_en, fetch_bubble, halted}); end
    @(posedge clk); #1;
    vectors++; if ({halted, pc_load} !== 2'b10) begin miscompares++; $display("[TB] FAIL halt_halted: got %b want 10", {halted, pc_load}); end
  endtask

  task automatic test_step;
    send_cmd(STEP, 9'd0, 32'd0);
    vectors++; if ({pipe_en, fetch_bubble, cmd_ready} !== 3'b100) begin miscompares++; $display("[TB] FAIL step_cycle: got %b want 100", {pipe_en, fetch_bubble, cmd_ready}); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if ({pipe_en, fetch_bubble, pc_load} !== 3'b110) begin miscompares++; $display("[TB] FAIL step_drain%0d: got %b want 110", i, {pipe_en, fetch_bubble, pc_load}); end
      @(posedge clk); #1;
    end
    vectors++; if ({pc_load, pc_load_addr} !== {1'b1, 9'h024}) begin miscompares++; $display("[TB] FAIL step_pc_load: got %b/%h want 1/024", pc_load, pc_load_addr); end
    @(posedge clk); #1;
    vectors++; if ({halted, cycle_cnt} !== {1'b1, 32'd20}) begin miscompares++; $display("[TB] FAIL step_done: got %b/%0d want 1/20", halted, cycle_cnt); end
  endtask

  task automatic test_cmd_err;
    int k;
    send_cmd(RUN, 9'd0, 32'd0);
`ifndef PIPE_CTRL_BREAKPOINT_EN
    send_cmd(SETBP, 9'h030, 32'd0);
    vectors++; if (cmd_err !== 1'b0) begin miscompares++; $display("[TB] FAIL err_bp_as_nop: got %b want 0", cmd_err); end
`endif
    send_cmd(WR, 9'h005, 32'h1234_5678);
    vectors++; if ({imem_we, cmd_err, pipe_en} !== 3'b011) begin miscompares++; $display("[TB] FAIL err_write_in_run: got %b want 011", {imem_we, cmd_err, pipe_en}); end
    vectors++; if (imem_addr !== pc_if) begin miscompares++; $display("[TB] FAIL err_addr_mux: got %h want %h", imem_addr, pc_if); end
    send_cmd(HALT, 9'd0, 32'd0);
    k = 0;
    while (halted !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    vectors++; if (k != 5) begin miscompares++; $display("[TB] FAIL err_halt_latency: got %0d want 5 cycles", k); end
    vectors++; if (cmd_err !== 1'b1) begin miscompares++; $display("[TB] FAIL err_sticky: got %b want 1", cmd_err); end
    send_cmd(NOP, 9'd0, 32'd0);
    vectors++; if (cmd_err !== 1'b0) begin miscompares++; $display("[TB] FAIL err_clear: got %b want 0", cmd_err); end
  endtask

`ifdef PIPE_CTRL_BREAKPOINT_EN
  task automatic test_breakpoint;
    int k;
    send_cmd(LDPC, 9'h010, 32'd0);
    send_cmd(SETBP, 9'h014, 32'd0);
    send_cmd(RUN, 9'd0, 32'd0);
    k = 0;
    while (fetch_bubble !== 1'b1 && k < 30) begin @(posedge clk); #1; k++; end
    vectors++; if (k != 5) begin miscompares++; $display("[TB] FAIL bp_entry: got %0d want 5 cycles", k); end
    repeat (4) @(posedge clk);
    #1;
    vectors++; if ({pc_load, pc_load_addr} !== {1'b1, 9'h014}) begin miscompares++; $display("[TB] FAIL bp_pc_load: got %b/%h want 1/014", pc_load, pc_load_addr); end
    @(posedge clk); #1;
    send_cmd(CLRBP, 9'd0, 32'd0);
    send_cmd(RUN, 9'd0, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    vectors++; if ({pipe_en, fetch_bubble} !== 2'b10) begin miscompares++; $display("[TB] FAIL bp_cleared: got %b want 10", {pipe_en, fetch_bubble}); end
    send_cmd(HALT, 9'd0, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_halted: got %b want 1", halted); end
  endtask
`endif

  task automatic test_reset_mid_drain;
    int seen;
    send_cmd(RUN, 9'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    send_cmd(HALT, 9'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    vectors++; if ({pipe_en, fetch_bubble, pc_load, halted, cmd_ready} !== 5'b00010) begin miscompares++; $display("[TB] FAIL mid_rst_flags: got %b want 00010", {pipe_en, fetch_bubble, pc_load, halted, cmd_ready}); end
    vectors++; if ({cycle_cnt, pc_load_addr} !== 41'd0) begin miscompares++; $display("[TB] FAIL mid_rst_regs: got %0d/%h want 0/000", cycle_cnt, pc_load_addr); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (pc_load === 1'b1) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("[TB] FAIL mid_rst_no_pc_load: got %0d pulses want 0", seen); end
    vectors++; if ({halted, pipe_en} !== 2'b10) begin miscompares++; $display("[TB] FAIL mid_rst_idle: got %b want 10", {halted, pipe_en}); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write_imem();
    test_run_halt();
    test_step();
    test_cmd_err();
`ifdef PIPE_CTRL_BREAKPOINT_EN
    test_breakpoint();
`endif
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

Run/halt sequencer and instruction-memory port arbiter for the 5-stage pipeline datapath. It replaces the tied-high pipeline register enable with a controlled `pipe_en`, shares the Icache write/address port between a host command interface and the core fetch PC, and drains in-flight instructions cleanly on halt or single-step. It sits between the host register interface and `pipeline_datapath`.

## Interface
- `PC_W`, 9: instruction address width.
- `DATA_W`, 32: instruction width.
- `DRAIN_CYCLES`, 4: bubble cycles needed to retire in-flight instructions.
- `CNT_W`, 32: run-cycle counter width.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  3  0 NOP, 1 WRITE_IMEM, 2 RUN, 3 HALT, 4 STEP, 5 LOAD_PC, 6 SET_BP, 7 CLR_BP.
- `cmd_addr`  in  PC_W  imem, PC or breakpoint address.
- `cmd_wdata`  in  DATA_W  imem write data.
- `pc_if`  in  PC_W  core fetch PC.
- `imem_addr`  out  PC_W  Icache address.
- `imem_din`  out  DATA_W  Icache write data.
- `imem_we`  out  1  Icache write enable.
- `pipe_en`  out  1  pipeline register/PC enable.
- `fetch_bubble`  out  1  forces the IF/ID flush input.
- `pc_load`  out  1  one-cycle PC load pulse.
- `pc_load_addr`  out  PC_W  PC load value.
- `halted`  out  1  high in IDLE.
- `cmd_err`  out  1  sticky: command dropped while running.
- `cycle_cnt`  out  CNT_W  cycles spent in RUN, saturating.

## Operation
- States: IDLE, RUN, STEP, DRAIN.
- IDLE: `pipe_en`=0, `cmd_ready`=1, imem port driven by host registers. WRITE_IMEM: pulses `imem_we` with `cmd_addr`/`cmd_wdata`. LOAD_PC: pulses `pc_load` with `cmd_addr`. RUN→RUN. STEP→STEP. HALT/NOP accepted, no effect. Any accepted command clears `cmd_err`.
- RUN: `pipe_en`=1, `imem_addr`=`pc_if` combinationally, `imem_we`=0, `cmd_ready`=1. HALT→DRAIN. Other non-NOP ops are dropped and set `cmd_err`. `cycle_cnt` +1 per RUN cycle, saturating at all-ones.
- STEP: exactly one cycle with `pipe_en`=1 and no bubble, then DRAIN; `cmd_ready`=0.
- DRAIN: latch `resume_pc`=`pc_if` on entry. Hold `pipe_en`=1, `fetch_bubble`=1 for DRAIN_CYCLES cycles (down-counter), `cmd_ready`=0. On exit, pulse `pc_load` with `resume_pc`, then IDLE.
- Boundary cases: HALT and breakpoint in the same cycle cause a single DRAIN. Breakpoint is ignored in STEP. Reset mid-DRAIN goes to IDLE with no `pc_load`. WRITE_IMEM at address 2^PC_W−1 is valid (no wrap logic).

## Timing
- All outputs are registered except `imem_addr` in RUN/STEP/DRAIN, which is a combinational mux of `pc_if`.
- Command to effect is 1 cycle: handshake at edge N gives `imem_we`/`pc_load` high during cycle N+1, for exactly one cycle.
- RUN→HALT: handshake at N, DRAIN covers N+1..N+DRAIN_CYCLES, `pc_load` at N+DRAIN_CYCLES+1, `halted` rises at N+DRAIN_CYCLES+2.
- Reset values: state IDLE, `halted`=1, `cmd_ready`=0 while `rst` is low, and every other output 0, `cycle_cnt`=0.

## Configuration
- `PIPE_CTRL_BREAKPOINT_EN` defined: SET_BP stores `bp_addr` and sets `bp_valid`; CLR_BP clears it. In RUN, `pc_if`==`bp_addr` with `bp_valid` enters DRAIN with `resume_pc`=`bp_addr`.
- Undefined: ops 6/7 are accepted as NOP and there is no comparator.

## Structure
- Package `pipe_ctrl_pkg`: op encodings, state encodings, default DRAIN_CYCLES.
- One sub-module, `pipe_ctrl_bp`: breakpoint register and comparator, instantiated only under the macro.

## Test plan
- After reset, WRITE_IMEM addr 0x010 data 0xDEADBEEF → `imem_we` high for exactly one cycle with addr 0x010 and din 0xDEADBEEF; `pipe_en` stays 0.
- LOAD_PC 0x010, RUN for 20 cycles, HALT → 4 bubble cycles, `pc_load` with the `pc_if` value captured at the HALT handshake, `cycle_cnt`=20, `halted`=1.
- STEP from IDLE → exactly one un-bubbled `pipe_en` cycle, 4 drain cycles, `pc_load`=previous PC+1.
- WRITE_IMEM during RUN → no `imem_we`, `cmd_err`=1; next accepted NOP in IDLE clears it.
- With the macro defined, SET_BP 0x014, run from 0x010 → DRAIN entered when `pc_if`=0x014, `pc_load_addr`=0x014.
- Assert `rst` low in the 2nd DRAIN cycle → IDLE, all outputs at reset values, no `pc_load` pulse.
